// File: rtl/video_buffer_decoder.sv
// Command decoder for the Nios video_buffer PIO. It turns toggle-strobed words into
// writes on a 1-bpp CHIP-8 framebuffer and provides a 1-cycle pixel read port for scan-out.
module video_buffer_decoder #(
   parameter int FB_COLS = 64,
   parameter int FB_ROWS = 32,
   parameter int ADDR_W  = 8
) (
   input  logic        clk_clk,
   input  logic        reset_reset,
   input  logic [15:0] video_buffer_word,
   output logic [7:0]  periphery_status,
   input  logic [5:0]  rd_x,
   input  logic [4:0]  rd_y,
   output logic        rd_pixel,
   output logic        frame_present
);
   localparam int DEPTH     = FB_COLS * FB_ROWS / 8;
   localparam int ROW_BYTES = FB_COLS / 8;
   localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(ROW_BYTES);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   localparam logic [2:0] OP_SET_ADDR = 3'd1;
   localparam logic [2:0] OP_WRITE    = 3'd2;
   localparam logic [2:0] OP_XOR      = 3'd3;
   localparam logic [2:0] OP_CLEAR    = 3'd4;
   localparam logic [2:0] OP_CLR_COLL = 3'd5;
   localparam logic [2:0] OP_PRESENT  = 3'd6;

   typedef enum logic [1:0] {IDLE, XOR_WR, CLEAR} state_t;

   state_t            state_reg;
   logic [15:0]       cmd_q;
   logic              ack_tog_reg;
   logic              collision_reg;
   logic              frame_present_reg;
   logic [ADDR_W-1:0] waddr_reg;
   logic [ADDR_W-1:0] caddr_reg;
   logic [7:0]        xor_data_reg;
   logic [ADDR_W-1:0] xor_step_reg;
   logic [2:0]        rd_bit_reg;
   logic              rd_valid_reg;

   logic [7:0]        mem [DEPTH];
   logic [7:0]        xor_old_reg;
   logic [7:0]        rd_byte_reg;

   logic              cmd_new;
   logic [2:0]        opcode;
   logic [7:0]        cmd_data;
   logic [ADDR_W-1:0] cmd_step;
   logic [ADDR_W-1:0] rd_addr;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [7:0]        wr_data;
   logic              unused_cmd_bits;

   assign cmd_new         = (state_reg == IDLE) && (cmd_q[15] != ack_tog_reg);
   assign opcode          = cmd_q[14:12];
   assign cmd_data        = cmd_q[7:0];
   assign cmd_step        = cmd_q[8] ? ROW_STEP : ADDR_W'(1);
   assign unused_cmd_bits = ^cmd_q[11:9];
   assign rd_addr         = ADDR_W'(rd_y) * ROW_STEP + ADDR_W'(rd_x[5:3]);

   // Single write port shared by WRITE, the XOR write-back and the clear sweep.
   always_comb begin
      wr_en   = 1'b0;
      wr_addr = waddr_reg;
      wr_data = cmd_data;
      case (state_reg)
         IDLE:   wr_en = cmd_new && (opcode == OP_WRITE);
         XOR_WR: begin
            wr_en   = 1'b1;
            wr_data = xor_old_reg ^ xor_data_reg;
         end
         CLEAR:  begin
            wr_en   = 1'b1;
            wr_addr = caddr_reg;
            wr_data = 8'h00;
         end
         default: ;
      endcase
   end

   // Read-first RAM: both registered reads see the byte as it was before a same-cycle write.
   always_ff @(posedge clk_clk) begin
      if (wr_en)
         mem[wr_addr] <= wr_data;
      xor_old_reg <= mem[waddr_reg];
      rd_byte_reg <= mem[rd_addr];
   end

   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         state_reg         <= IDLE;
         cmd_q             <= 16'h0000;
         ack_tog_reg       <= 1'b0;
         collision_reg     <= 1'b0;
         frame_present_reg <= 1'b0;
         waddr_reg         <= '0;
         caddr_reg         <= '0;
         xor_data_reg      <= 8'h00;
         xor_step_reg      <= '0;
         rd_bit_reg        <= 3'd0;
         rd_valid_reg      <= 1'b0;
      end else begin
         cmd_q             <= video_buffer_word;
         frame_present_reg <= 1'b0;
         rd_bit_reg        <= 3'd7 - rd_x[2:0];
         rd_valid_reg      <= 1'b1;
         case (state_reg)
            IDLE: begin
               if (cmd_new) begin
                  case (opcode)
                     OP_SET_ADDR: waddr_reg <= ADDR_W'(cmd_data);
                     OP_WRITE:    waddr_reg <= waddr_reg + cmd_step;
                     OP_XOR: begin
                        xor_data_reg <= cmd_data;
                        xor_step_reg <= cmd_step;
                        state_reg    <= XOR_WR;
                     end
                     OP_CLEAR: begin
                        caddr_reg <= '0;
                        state_reg <= CLEAR;
                     end
                     OP_CLR_COLL: collision_reg     <= 1'b0;
                     OP_PRESENT:  frame_present_reg <= 1'b1;
                     default: ;
                  endcase
                  // Multi-cycle commands acknowledge when they finish.
                  if (opcode != OP_XOR && opcode != OP_CLEAR)
                     ack_tog_reg <= cmd_q[15];
               end
            end
            XOR_WR: begin
               collision_reg <= collision_reg | (|(xor_old_reg & xor_data_reg));
               waddr_reg     <= waddr_reg + xor_step_reg;
               ack_tog_reg   <= ~ack_tog_reg;
               state_reg     <= IDLE;
            end
            CLEAR: begin
               caddr_reg <= caddr_reg + ADDR_W'(1);
               if (caddr_reg == LAST_ADDR) begin
                  ack_tog_reg <= ~ack_tog_reg;
                  state_reg   <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign periphery_status = {5'b00000, collision_reg, state_reg != IDLE, ack_tog_reg};
   assign frame_present    = frame_present_reg;
   assign rd_pixel         = rd_valid_reg & rd_byte_reg[rd_bit_reg];
endmodule

// File: tb/tb_video_buffer_decoder.sv
// Bench for video_buffer_decoder: directed command table, hand sequences for CLEAR
// queuing and reset during CLEAR, and random commands checked against a byte-array model.
module tb_video_buffer_decoder;
   logic        clk_clk = 1'b0;
   logic        reset_reset = 1'b0;
   logic [15:0] video_buffer_word = 16'h0000;
   logic [7:0]  periphery_status;
   logic [5:0]  rd_x = 6'd0;
   logic [4:0]  rd_y = 5'd0;
   logic        rd_pixel;
   logic        frame_present;

   int total = 0;
   int bad   = 0;

   always #5 clk_clk = ~clk_clk;

   video_buffer_decoder dut (
      .clk_clk           (clk_clk),
      .reset_reset       (reset_reset),
      .video_buffer_word (video_buffer_word),
      .periphery_status  (periphery_status),
      .rd_x              (rd_x),
      .rd_y              (rd_y),
      .rd_pixel          (rd_pixel),
      .frame_present     (frame_present)
   );

   typedef struct {
      int         op;
      bit         stride;
      logic [7:0] data;
      int         chk_addr;
      logic [7:0] chk_val;
      logic [7:0] status;
   } vec_t;

   // Reference model: framebuffer bytes plus the software-visible registers.
   logic [7:0] m_mem [256];
   int         m_waddr = 0;
   bit         m_coll = 1'b0;
   bit         m_tog = 1'b0;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   function automatic int exp_status();
      return {29'd0, m_coll, 1'b0, m_tog};
   endfunction

   task automatic model_apply(input int op, input bit stride, input logic [7:0] data);
      int step;
      step = stride ? 8 : 1;
      case (op)
         1: m_waddr = data;
         2: begin
            m_mem[m_waddr] = data;
            m_waddr = (m_waddr + step) % 256;
         end
         3: begin
            if ((m_mem[m_waddr] & data) != 8'h00) m_coll = 1'b1;
            m_mem[m_waddr] = m_mem[m_waddr] ^ data;
            m_waddr = (m_waddr + step) % 256;
         end
         4: for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;
         5: m_coll = 1'b0;
         default: ;
      endcase
      m_tog = ~m_tog;
   endtask

   // Present one command and wait for its ack; latency counted in edges from the drive.
   task automatic send(input int op, input bit stride, input logic [7:0] data);
      int c, lat, busy_cnt, fp_cnt, fp_at;
      bit old;
      old = m_tog;
      lat = (op == 3) ? 3 : (op == 4) ? 258 : 2;
      video_buffer_word = {~old, 3'(op), 3'b000, stride, data};
      c = 0; busy_cnt = 0; fp_cnt = 0; fp_at = -1;
      do begin
         @(posedge clk_clk); #1;
         c++;
         if (frame_present) begin fp_cnt++; fp_at = c; end
         if (periphery_status[1]) busy_cnt++;
      end while (periphery_status[0] == old && c < 400);
      check("ack_latency", c, lat);
      check("busy_cycles", busy_cnt, (op == 3) ? 1 : (op == 4) ? 256 : 0);
      model_apply(op, stride, data);
      check("status", periphery_status, exp_status());
      check("present_pulses", fp_cnt, (op == 6) ? 1 : 0);
      if (op == 6) begin
         check("present_cycle", fp_at, 2);
         @(posedge clk_clk); #1;
         check("present_drop", frame_present, 0);
      end
   endtask

   task automatic read_byte(input int addr, output logic [7:0] val);
      val = 8'h00;
      for (int i = 0; i < 8; i++) begin
         rd_x = 6'((addr % 8) * 8 + i);
         rd_y = 5'(addr / 8);
         @(posedge clk_clk); #1;
         val[7-i] = rd_pixel;
      end
   endtask

   task automatic read_pixel(input int x, input int y, output logic p);
      rd_x = 6'(x);
      rd_y = 5'(y);
      @(posedge clk_clk); #1;
      p = rd_pixel;
   endtask

   task automatic verify_all(input string name);
      logic [7:0] v;
      int errs;
      errs = 0;
      for (int a = 0; a < 256; a++) begin
         read_byte(a, v);
         if (v !== m_mem[a]) errs++;
      end
      check(name, errs, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: actual=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t       vecs [24];
      logic [7:0] v;
      logic       p;
      bit         old;
      int         op;

      vecs[0]  = '{1, 1'b0, 8'h05,  -1, 8'h00, 8'h01};
      vecs[1]  = '{2, 1'b0, 8'h81,   5, 8'h81, 8'h00};
      vecs[2]  = '{2, 1'b0, 8'h7E,   6, 8'h7E, 8'h01};
      vecs[3]  = '{1, 1'b0, 8'h00,  -1, 8'h00, 8'h00};
      vecs[4]  = '{2, 1'b0, 8'hF0,   0, 8'hF0, 8'h01};
      vecs[5]  = '{1, 1'b0, 8'h00,  -1, 8'h00, 8'h00};
      vecs[6]  = '{3, 1'b0, 8'h3C,   0, 8'hCC, 8'h05};
      vecs[7]  = '{5, 1'b0, 8'h00,  -1, 8'h00, 8'h00};
      vecs[8]  = '{1, 1'b0, 8'h00,  -1, 8'h00, 8'h01};
      vecs[9]  = '{3, 1'b0, 8'h03,   0, 8'hCF, 8'h00};
      vecs[10] = '{1, 1'b0, 8'hFA,  -1, 8'h00, 8'h01};
      vecs[11] = '{2, 1'b1, 8'h11, 250, 8'h11, 8'h00};
      vecs[12] = '{2, 1'b0, 8'h22,   2, 8'h22, 8'h01};
      vecs[13] = '{1, 1'b0, 8'hFA,  -1, 8'h00, 8'h00};
      vecs[14] = '{3, 1'b1, 8'hFF, 250, 8'hEE, 8'h05};
      vecs[15] = '{2, 1'b0, 8'h33,   2, 8'h33, 8'h04};
      vecs[16] = '{1, 1'b0, 8'hFF,  -1, 8'h00, 8'h05};
      vecs[17] = '{2, 1'b0, 8'h44, 255, 8'h44, 8'h04};
      vecs[18] = '{2, 1'b0, 8'h55,   0, 8'h55, 8'h05};
      vecs[19] = '{7, 1'b0, 8'h99,   0, 8'h55, 8'h04};
      vecs[20] = '{2, 1'b0, 8'h66,   1, 8'h66, 8'h05};
      vecs[21] = '{0, 1'b0, 8'h00,  -1, 8'h00, 8'h04};
      vecs[22] = '{6, 1'b0, 8'h00,  -1, 8'h00, 8'h05};
      vecs[23] = '{5, 1'b0, 8'h00,  -1, 8'h00, 8'h00};

      #1 reset_reset = 1'b1;
      #1;
      check("reset_status", periphery_status, 0);
      check("reset_present", frame_present, 0);
      check("reset_pixel", rd_pixel, 0);
      @(posedge clk_clk); @(posedge clk_clk); #1;
      reset_reset = 1'b0;
      @(posedge clk_clk); #1;
      check("idle_status", periphery_status, 0);

      for (int i = 0; i < 24; i++) begin
         send(vecs[i].op, vecs[i].stride, vecs[i].data);
         check($sformatf("vec%0d_status", i), periphery_status, vecs[i].status);
         if (vecs[i].chk_addr >= 0) begin
            read_byte(vecs[i].chk_addr, v);
            check($sformatf("vec%0d_byte", i), v, vecs[i].chk_val);
         end
         $display("vec %0d op=%0d data=0x%02h status=0x%02h", i, vecs[i].op, vecs[i].data, periphery_status);
      end

      read_pixel(40, 0, p); check("pixel_40_0", p, 1);
      read_pixel(47, 0, p); check("pixel_47_0", p, 1);
      read_pixel(41, 0, p); check("pixel_41_0", p, 0);

      send(4, 1'b0, 8'h00);
      verify_all("clear_all_zero");

      for (int i = 0; i < 300; i++) begin
         op = $urandom_range(0, 7);
         if (op == 4) op = 2;
         v = 8'($urandom);
         send(op, 1'($urandom_range(0, 1)), v);
      end
      $display("random commands done status=0x%02h", periphery_status);
      verify_all("random_mem");

      // A word presented while CLEAR is busy must wait until the sweep finishes.
      old = m_tog;
      video_buffer_word = {~old, 3'd4, 3'b000, 1'b0, 8'h00};
      for (int c = 1; c <= 259; c++) begin
         @(posedge clk_clk); #1;
         if (c == 50) video_buffer_word = {old, 3'd2, 3'b000, 1'b0, 8'h5A};
         if (c == 257) check("queued_busy_end", periphery_status[1:0], {1'b1, old});
         if (c == 258) check("clear_ack", periphery_status[1:0], {1'b0, ~old});
         if (c == 259) check("queued_ack", periphery_status[1:0], {1'b0, old});
      end
      model_apply(4, 1'b0, 8'h00);
      model_apply(2, 1'b0, 8'h5A);
      check("status_after_queue", periphery_status, exp_status());
      verify_all("queued_write_mem");

      send(1, 1'b0, 8'h00);
      for (int i = 0; i < 256; i++) begin
         v = 8'($urandom);
         send(2, 1'b0, v);
      end
      verify_all("fill_mem");

      // Reset after 100 bytes of a CLEAR have been written.
      old = m_tog;
      video_buffer_word = {~old, 3'd4, 3'b000, 1'b0, 8'h00};
      @(posedge clk_clk); #1;
      @(posedge clk_clk); #1;
      check("clear_started", periphery_status[1], 1);
      repeat (100) @(posedge clk_clk);
      #1 reset_reset = 1'b1;
      video_buffer_word = 16'h0000;
      #1;
      check("midclear_reset_status", periphery_status, 0);
      check("midclear_reset_present", frame_present, 0);
      check("midclear_reset_pixel", rd_pixel, 0);
      for (int i = 0; i < 100; i++) m_mem[i] = 8'h00;
      m_tog = 1'b0; m_coll = 1'b0; m_waddr = 0;
      @(posedge clk_clk); @(posedge clk_clk); #1;
      reset_reset = 1'b0;
      @(posedge clk_clk); #1;
      check("post_reset_status", periphery_status, 0);
      verify_all("partial_clear_mem");

      send(2, 1'b0, 8'hA5);
      send(3, 1'b0, 8'hFF);
      send(1, 1'b0, 8'd150);
      send(3, 1'b0, 8'hFF);
      $display("post-reset commands status=0x%02h", periphery_status);
      verify_all("post_reset_mem");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
